// File: rtl/masked_sbox_layer_pipe.sv
// masked_sbox_layer_pipe: NUM_SBOX parallel 3-share masked Q294 S-box stages
// (CF register + XOR_3 compression) in a valid/ready pipeline with optional output register.
module masked_sbox_layer_pipe #(
    parameter int NUM_SBOX = 16,
    parameter bit OUT_REG  = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4*NUM_SBOX-1:0]    in_sh0,
    input  logic [4*NUM_SBOX-1:0]    in_sh1,
    input  logic [4*NUM_SBOX-1:0]    in_sh2,
    input  logic [16*NUM_SBOX-1:0]   rnd,
    input  logic                     rnd_valid,
    output logic                     rnd_take,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4*NUM_SBOX-1:0]    out_sh0,
    output logic [4*NUM_SBOX-1:0]    out_sh1,
    output logic [4*NUM_SBOX-1:0]    out_sh2,
    output logic                     busy
);
    localparam int W = 4 * NUM_SBOX;
    localparam int C = 18 * NUM_SBOX;
    localparam int P = 2 * NUM_SBOX;

    // Output bit i = lin ^ a*b (bit1: x1 ^ x3x2, bit0: x0 ^ (x3^x2)x1). Share j only sees
    // input shares j+1, j+2; the fresh bits in each group of three CFs XOR to zero.
    function automatic logic [17:0] cf_cells(input logic [3:0] s0, input logic [3:0] s1,
                                             input logic [3:0] s2, input logic [15:0] rr);
        logic [3:0]  x [3];
        logic [2:0]  a, b, l;
        logic [17:0] f;
        int          u, v;
        x[0] = s0;
        x[1] = s1;
        x[2] = s2;
        f = '0;
        a = '0;
        b = '0;
        l = '0;
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 3; s++) begin
                l[s] = x[s][i];
                a[s] = (i == 1) ? x[s][3] : x[s][3] ^ x[s][2];
                b[s] = (i == 1) ? x[s][2] : x[s][1];
            end
            for (int j = 0; j < 3; j++) begin
                u = (j + 1) % 3;
                v = (j + 2) % 3;
                f[9*i+3*j]   = l[u] ^ (a[u] & b[u]) ^ rr[6*i+j] ^ rr[6*i+(j+1)%3];
                f[9*i+3*j+1] = (a[u] & b[v]) ^ rr[6*i+3+j] ^ rr[6*i+3+(j+1)%3];
                f[9*i+3*j+2] = (a[v] & b[u]) ^
                               ((j == 2) ? rr[12+2*i] ^ rr[13+2*i] : rr[12+2*i+j]);
            end
        end
        return f;
    endfunction

    logic           v1_q, v1_d, adv1, xfer_in;
    logic [C-1:0]   cf_q, cf_d;
    logic [P-1:0]   pt_q [3];
    logic [P-1:0]   pt_d [3];
    logic [W-1:0]   in_sh [3];
    logic [W-1:0]   c_sh [3];

    assign in_sh[0] = in_sh0;
    assign in_sh[1] = in_sh1;
    assign in_sh[2] = in_sh2;
    assign in_ready = rst_n & rnd_valid & (~v1_q | adv1);
    assign xfer_in  = in_valid & in_ready;
    assign rnd_take = xfer_in;

    always_comb begin
        v1_d = xfer_in | (v1_q & ~adv1);
        cf_d = cf_q;
        for (int j = 0; j < 3; j++) begin
            pt_d[j] = pt_q[j];
            c_sh[j] = '0;
        end
        for (int k = 0; k < NUM_SBOX; k++) begin
            if (xfer_in) begin
                cf_d[18*k +: 18] = cf_cells(in_sh0[4*k +: 4], in_sh1[4*k +: 4], in_sh2[4*k +: 4],
                                            rnd[16*k +: 16]);
                for (int j = 0; j < 3; j++)
                    pt_d[j][2*k +: 2] = in_sh[(j+1)%3][4*k+2 +: 2];
            end
            for (int j = 0; j < 3; j++)
                c_sh[j][4*k +: 4] = {pt_q[j][2*k +: 2], ^cf_q[18*k+9+3*j +: 3], ^cf_q[18*k+3*j +: 3]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            cf_q    <= '0;
            pt_q[0] <= '0;
            pt_q[1] <= '0;
            pt_q[2] <= '0;
        end else begin
            v1_q    <= v1_d;
            cf_q    <= cf_d;
            pt_q[0] <= pt_d[0];
            pt_q[1] <= pt_d[1];
            pt_q[2] <= pt_d[2];
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic           v2_q, v2_d;
        logic [W-1:0]   o_q [3];
        logic [W-1:0]   o_d [3];
        assign adv1 = v1_q & (~v2_q | out_ready);
        always_comb begin
            v2_d = adv1 | (v2_q & ~out_ready);
            for (int j = 0; j < 3; j++)
                o_d[j] = adv1 ? c_sh[j] : o_q[j];
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v2_q   <= 1'b0;
                o_q[0] <= '0;
                o_q[1] <= '0;
                o_q[2] <= '0;
            end else begin
                v2_q   <= v2_d;
                o_q[0] <= o_d[0];
                o_q[1] <= o_d[1];
                o_q[2] <= o_d[2];
            end
        end
        assign out_valid = v2_q;
        assign busy      = v1_q | v2_q;
        assign out_sh0   = o_q[0];
        assign out_sh1   = o_q[1];
        assign out_sh2   = o_q[2];
    end else begin : g_comb_out
        assign adv1      = out_ready;
        assign out_valid = v1_q;
        assign busy      = v1_q;
        assign out_sh0   = c_sh[0];
        assign out_sh1   = c_sh[1];
        assign out_sh2   = c_sh[2];
    end
endmodule

// File: tb/tb_masked_sbox_layer_pipe.sv
// tb_masked_sbox_layer_pipe: directed checks of a 16-box/latency-1 build and a 1-box/latency-2 build
// against a hand-computed Q294 table.
module tb_masked_sbox_layer_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] HI = 64'hCCCC_CCCC_CCCC_CCCC;

    logic          a_in_valid, a_in_ready, a_rnd_valid, a_rnd_take, a_out_valid, a_out_ready, a_busy;
    logic [63:0]   a_in_sh0, a_in_sh1, a_in_sh2, a_out_sh0, a_out_sh1, a_out_sh2;
    logic [255:0]  a_rnd;
    logic          b_in_valid, b_in_ready, b_rnd_valid, b_rnd_take, b_out_valid, b_out_ready, b_busy;
    logic [3:0]    b_in_sh0, b_in_sh1, b_in_sh2, b_out_sh0, b_out_sh1, b_out_sh2;
    logic [15:0]   b_rnd;

    masked_sbox_layer_pipe #(.NUM_SBOX(16), .OUT_REG(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_sh0(a_in_sh0), .in_sh1(a_in_sh1), .in_sh2(a_in_sh2), .rnd(a_rnd),
        .rnd_valid(a_rnd_valid), .rnd_take(a_rnd_take), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_sh0(a_out_sh0), .out_sh1(a_out_sh1), .out_sh2(a_out_sh2),
        .busy(a_busy));

    masked_sbox_layer_pipe #(.NUM_SBOX(1), .OUT_REG(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_sh0(b_in_sh0), .in_sh1(b_in_sh1), .in_sh2(b_in_sh2), .rnd(b_rnd),
        .rnd_valid(b_rnd_valid), .rnd_take(b_rnd_take), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_sh0(b_out_sh0), .out_sh1(b_out_sh1), .out_sh2(b_out_sh2),
        .busy(b_busy));

    // Q294: y = {x3, x2, x1 ^ x3x2, x0 ^ (x3^x2)x1}, worked out by hand
    logic [3:0] qt [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h6,
                            4'h8, 4'h9, 4'hB, 4'hA, 4'hE, 4'hF, 4'hC, 4'hD};

    typedef struct { logic [3:0] x, s1, s2, y; logic [15:0] r; } vec_t;
    typedef struct { logic [63:0] y, h0, h1, h2; } exp_t;
    vec_t tv [16];
    exp_t q [$];
    exp_t pend;
    int   n_chk = 0, n_fail = 0, n_out = 0, n_take = 0, cyc = 0;
    logic a_acc;

    always_ff @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] q16(input logic [63:0] x);
        logic [63:0] y;
        for (int k = 0; k < 16; k++) y[4*k +: 4] = qt[x[4*k +: 4]];
        return y;
    endfunction

    task automatic set_a(input logic [63:0] x);
        logic [63:0] s1, s2;
        s1 = {$urandom, $urandom};
        s2 = {$urandom, $urandom};
        a_in_sh1 = s1;
        a_in_sh2 = s2;
        a_in_sh0 = x ^ s1 ^ s2;
        for (int i = 0; i < 8; i++) a_rnd[32*i +: 32] = $urandom;
        pend.y  = q16(x);
        pend.h0 = s1 & HI;
        pend.h1 = s2 & HI;
        pend.h2 = (x ^ s1 ^ s2) & HI;
        a_in_valid = 1'b1;
    endtask

    // One clock: sample handshakes on the falling edge, score dut_a outputs, return 1 after rise
    task automatic tick();
        exp_t e;
        @(negedge clk);
        a_acc = a_in_valid & a_in_ready;
        if (a_acc) q.push_back(pend);
        if (a_rnd_take) n_take++;
        if (rst_n && a_out_valid && a_out_ready) begin
            if (q.size() == 0) begin
                chk("a_spurious_out", 64'(q.size()), 64'd1);
            end else begin
                e = q.pop_front();
                chk("a_func", a_out_sh0 ^ a_out_sh1 ^ a_out_sh2, e.y);
                chk("a_rot_sh0", a_out_sh0 & HI, e.h0);
                chk("a_rot_sh1", a_out_sh1 & HI, e.h1);
                chk("a_rot_sh2", a_out_sh2 & HI, e.h2);
                n_out++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a(input int bound);
        a_acc = 1'b0;
        for (int c = 0; c < bound && !a_acc; c++) tick();
        chk("a_accept", 64'(a_acc), 64'd1);
    endtask

    task automatic b_send(input logic [3:0] x, input logic [3:0] s1, input logic [3:0] s2,
                          input logic [15:0] r);
        logic acc;
        acc = 1'b0;
        b_in_sh1 = s1;
        b_in_sh2 = s2;
        b_in_sh0 = x ^ s1 ^ s2;
        b_rnd = r;
        b_in_valid = 1'b1;
        for (int c = 0; c < 4 && !acc; c++) begin
            @(negedge clk);
            acc = b_in_ready;
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        chk("b_accept", 64'(acc), 64'd1);
    endtask

    initial begin
        int t0, k0, c0, c1, lat;
        logic [63:0] o0, o1, o2;
        logic [3:0] s0;
        for (int i = 0; i < 16; i++) begin
            tv[i].x  = 4'(i);
            tv[i].y  = qt[i];
            tv[i].s1 = 4'($urandom_range(0, 15));
            tv[i].s2 = 4'($urandom_range(0, 15));
            tv[i].r  = 16'($urandom);
        end
        tv[5].s1 = 4'hC;
        a_in_valid = 0; a_in_sh0 = '0; a_in_sh1 = '0; a_in_sh2 = '0; a_rnd = '0;
        a_rnd_valid = 1; a_out_ready = 1;
        b_in_valid = 0; b_in_sh0 = '0; b_in_sh1 = '0; b_in_sh2 = '0; b_rnd = '0;
        b_rnd_valid = 1; b_out_ready = 1;

        #12;
        chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_a_in_ready", 64'(a_in_ready), 64'd0);
        chk("rst_a_busy", 64'(a_busy), 64'd0);
        chk("rst_a_out", a_out_sh0 | a_out_sh1 | a_out_sh2, 64'd0);
        chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        chk("rst_b_in_ready", 64'(b_in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // all sixteen nibble values in one word, latency 1
        set_a(64'hFEDC_BA98_7654_3210);
        wait_a(4);
        a_in_valid = 0;
        chk("a_lat1", 64'(a_out_valid), 64'd1);
        tick();
        chk("a_exh_drained", 64'(q.size()), 64'd0);

        // 100 back-to-back words
        t0 = n_out; k0 = n_take; c0 = cyc;
        for (int i = 0; i < 100; i++) begin
            set_a({$urandom, $urandom});
            wait_a(4);
        end
        c1 = cyc;
        a_in_valid = 0;
        repeat (3) tick();
        chk("stream_cycles", 64'(c1 - c0), 64'd100);
        chk("stream_outs", 64'(n_out - t0), 64'd100);
        chk("stream_rnd_take", 64'(n_take - k0), 64'd100);
        chk("stream_drained", 64'(q.size()), 64'd0);

        // backpressure with pipe full
        t0 = n_out;
        a_out_ready = 0;
        set_a(64'h0123_4567_89AB_CDEF);
        wait_a(4);
        set_a(64'hA5A5_5A5A_0FF0_F00F);
        o0 = a_out_sh0; o1 = a_out_sh1; o2 = a_out_sh2;
        repeat (5) begin
            tick();
            chk("bp_in_ready", 64'(a_in_ready), 64'd0);
            chk("bp_out_valid", 64'(a_out_valid), 64'd1);
            chk("bp_hold0", a_out_sh0, o0);
            chk("bp_hold1", a_out_sh1, o1);
            chk("bp_hold2", a_out_sh2, o2);
        end
        a_out_ready = 1;
        wait_a(4);
        a_in_valid = 0;
        repeat (2) tick();
        chk("bp_outs", 64'(n_out - t0), 64'd2);
        chk("bp_drained", 64'(q.size()), 64'd0);

        // randomness starvation
        a_out_ready = 0;
        set_a(64'h1357_9BDF_2468_ACE0);
        wait_a(4);
        a_rnd_valid = 0;
        set_a(64'hFFFF_0000_FFFF_0000);
        a_out_ready = 1;
        #1;
        chk("starve_in_ready", 64'(a_in_ready), 64'd0);
        chk("starve_rnd_take", 64'(a_rnd_take), 64'd0);
        chk("starve_busy_full", 64'(a_busy), 64'd1);
        tick();
        chk("starve_busy_empty", 64'(a_busy), 64'd0);
        chk("starve_out_valid", 64'(a_out_valid), 64'd0);
        chk("starve_in_ready2", 64'(a_in_ready), 64'd0);
        chk("starve_rnd_take2", 64'(a_rnd_take), 64'd0);
        a_rnd_valid = 1;
        wait_a(4);
        a_in_valid = 0;
        repeat (2) tick();
        chk("starve_drained", 64'(q.size()), 64'd0);

        // asynchronous reset with a word held in stage 1
        a_out_ready = 0;
        set_a(64'hDEAD_BEEF_CAFE_F00D);
        wait_a(4);
        a_in_valid = 0;
        chk("mrst_pre_valid", 64'(a_out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(a_out_valid), 64'd0);
        chk("mrst_busy", 64'(a_busy), 64'd0);
        chk("mrst_out", a_out_sh0 | a_out_sh1 | a_out_sh2, 64'd0);
        chk("mrst_in_ready", 64'(a_in_ready), 64'd0);
        chk("mrst_rnd_take", 64'(a_rnd_take), 64'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        a_out_ready = 1;
        set_a(64'h0F1E_2D3C_4B5A_6978);
        wait_a(4);
        a_in_valid = 0;
        chk("mrst_first_valid", 64'(a_out_valid), 64'd1);
        repeat (2) tick();
        chk("mrst_drained", 64'(q.size()), 64'd0);

        // single-box build with output register: every nibble, latency 2, share rotation
        for (int i = 0; i < 16; i++) begin
            b_send(tv[i].x, tv[i].s1, tv[i].s2, tv[i].r);
            lat = 1;
            while (!b_out_valid && lat < 6) begin
                @(posedge clk);
                #1;
                lat++;
            end
            s0 = tv[i].x ^ tv[i].s1 ^ tv[i].s2;
            chk("b_lat2", 64'(lat), 64'd2);
            chk("b_func", 64'(b_out_sh0 ^ b_out_sh1 ^ b_out_sh2), 64'(tv[i].y));
            chk("b_rot_sh0", 64'(b_out_sh0[3:2]), 64'(tv[i].s1[3:2]));
            chk("b_rot_sh1", 64'(b_out_sh1[3:2]), 64'(tv[i].s2[3:2]));
            chk("b_rot_sh2", 64'(b_out_sh2[3:2]), 64'(s0[3:2]));
            @(posedge clk);
            #1;
        end

        // single-box build: both stages full under backpressure
        b_out_ready = 0;
        b_send(4'h6, 4'($urandom), 4'($urandom), 16'($urandom));
        b_send(4'hC, 4'($urandom), 4'($urandom), 16'($urandom));
        b_in_sh0 = 4'h3; b_in_sh1 = 4'h0; b_in_sh2 = 4'h0;
        b_in_valid = 1;
        repeat (3) begin
            chk("b_bp_valid", 64'(b_out_valid), 64'd1);
            chk("b_bp_in_ready", 64'(b_in_ready), 64'd0);
            chk("b_bp_hold", 64'(b_out_sh0 ^ b_out_sh1 ^ b_out_sh2), 64'h7);
            @(posedge clk);
            #1;
        end
        b_in_valid = 0;
        b_out_ready = 1;
        @(posedge clk);
        #1;
        chk("b_bp_second_valid", 64'(b_out_valid), 64'd1);
        chk("b_bp_second", 64'(b_out_sh0 ^ b_out_sh1 ^ b_out_sh2), 64'hE);
        @(posedge clk);
        #1;
        chk("b_bp_empty", 64'(b_out_valid), 64'd0);
        chk("b_bp_busy", 64'(b_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
